base_sel_ctrl: RTL



---
 rtl/base_sel_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/base_sel_ctrl.sv
`timescale 1ns/1ps
// Display-base selector: debounces next/prev buttons and steps DEC -> HEX -> OCT,
// deferring steps while the datapath holds lock.
module base_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_next_n,
    input  logic       key_prev_n,
    input  logic       lock,
    output logic [1:0] seletor,
    output logic       update,
    output logic       pending
);
    // state | meaning
    // DEC   | 00, decimal
    // HEX   | 01, hexadecimal
    // OCT   | 10, octal (11 is illegal and recovers to DEC)
    localparam logic [1:0] S_DEC = 2'b00;
    localparam logic [1:0] S_HEX = 2'b01;
    localparam logic [1:0] S_OCT = 2'b10;
    localparam logic [1:0] S_BAD = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Index 0 is the next key, index 1 the prev key.
    logic [1:0]       raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       press_q, press_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    logic [1:0] state_q, state_d;
    logic       upd_q, upd_d;
    logic       pend_q, pend_d;
    logic       dir_q, dir_d;
    logic       live, live_dir;

    assign raw = {~key_prev_n, ~key_next_n};

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            deb_d[k]   = deb_q[k];
            press_d[k] = 1'b0;
            cnt_d[k]   = cnt_q[k];
            if (sync2_q[k] == deb_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_LAST) begin
                deb_d[k]   = ~deb_q[k];
                press_d[k] = ~deb_q[k];
                cnt_d[k]   = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_ONE;
            end
        end
    end

    function automatic logic [1:0] step_base(input logic [1:0] s, input logic to_prev);
        case (s)
            S_DEC:   step_base = to_prev ? S_OCT : S_HEX;
            S_HEX:   step_base = to_prev ? S_DEC : S_OCT;
            default: step_base = to_prev ? S_HEX : S_DEC;
        endcase
    endfunction

    // Opposite presses in the same cycle cancel each other out.
    assign live     = press_q[0] ^ press_q[1];
    assign live_dir = press_q[1];

    always_comb begin
        state_d = state_q;
        upd_d   = 1'b0;
        pend_d  = pend_q;
        dir_d   = dir_q;
        if (state_q == S_BAD) begin
            state_d = S_DEC;
            upd_d   = 1'b1;
        end else if (lock) begin
            if (live) begin
                pend_d = 1'b1;
                dir_d  = live_dir;
            end
        end else if (live) begin
            state_d = step_base(state_q, live_dir);
            pend_d  = 1'b0;
            upd_d   = 1'b1;
        end else if (pend_q) begin
            state_d = step_base(state_q, dir_q);
            pend_d  = 1'b0;
            upd_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            press_q  <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            state_q  <= S_DEC;
            upd_q    <= 1'b0;
            pend_q   <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            press_q  <= press_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            state_q  <= state_d;
            upd_q    <= upd_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
        end
    end

    assign seletor = state_q;
    assign update  = upd_q;
    assign pending = pend_q;

endmodule
